// File: rtl/uart_sram_batch_bridge_pkg.sv
// rtl/uart_sram_batch_bridge_pkg.sv - shared states, bus release constant and mode encodings
package uart_sram_batch_bridge_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RX_POLL,
    RX_STROBE,
    RX_LATCH,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_SETUP,
    RD_LATCH,
    TX_DRIVE,
    TX_PULSE,
    TX_TBRE,
    TX_TSRE
  } state_t;

  localparam logic [15:0] HIGH = 16'bz;

  localparam logic MODE_ECHO  = 1'b0;
  localparam logic MODE_BATCH = 1'b1;

endpackage

// File: rtl/sram_word_port.sv
// rtl/sram_word_port.sv - RAM1 control/address decode for the 3-cycle write and 2-cycle read
module sram_word_port
  import uart_sram_batch_bridge_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  state_t            i_state,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_en_n,
  output logic              o_oe_n,
  output logic              o_we_n,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_drive
);

  always_comb begin
    o_en_n  = 1'b1;
    o_oe_n  = 1'b1;
    o_we_n  = 1'b1;
    o_drive = 1'b0;
    o_addr  = i_wr_addr;
    case (i_state)
      WR_SETUP: begin
        o_en_n  = 1'b0;
        o_drive = 1'b1;
      end
      WR_PULSE: begin
        o_en_n  = 1'b0;
        o_we_n  = 1'b0;
        o_drive = 1'b1;
      end
      WR_HOLD: begin
        o_en_n  = 1'b0;
        o_drive = 1'b1;
      end
      RD_SETUP: begin
        o_en_n = 1'b0;
        o_oe_n = 1'b0;
        o_addr = i_rd_addr;
      end
      RD_LATCH: o_addr = i_rd_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_sram_batch_bridge.sv
// rtl/uart_sram_batch_bridge.sv - UART to RAM1 batch collect/replay bridge; UART_SRAM_INC_EN adds +1 to each transmitted byte
module uart_sram_batch_bridge
  import uart_sram_batch_bridge_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int DEPTH     = 8,
  parameter int BASE_ADDR = 0,
  parameter int WRN_CYC   = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mode,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre,
  output logic              rdn,
  output logic              wrn,
  inout  wire  [15:0]       data,
  output logic              Ram1_EN,
  output logic              Ram1_OE,
  output logic              Ram1_WE,
  output logic [ADDR_W-1:0] Ram1_address,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  localparam int WC_W = $clog2(WRN_CYC + 1);
  localparam logic [ADDR_W-1:0] W_BASE = ADDR_W'(BASE_ADDR);

  if ((DEPTH < 1) || (WRN_CYC < 1) ||
      (longint'(BASE_ADDR) + longint'(DEPTH) > (longint'(1) << ADDR_W))) begin : g_bad_cfg
    $error("uart_sram_batch_bridge: DEPTH/BASE_ADDR exceed RAM1 or WRN_CYC < 1");
  end

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_len, r_word_cnt, r_rd_ptr;
  logic [15:0]       r_hold;
  logic [WC_W-1:0]   r_wcnt;

  logic [CNT_W-1:0]  w_word_inc, w_rd_inc;
  logic [15:0]       w_tx_word;
  logic              w_rdn, w_wrn, w_tx_drive, w_ram_drive;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;

  assign w_word_inc = r_word_cnt + CNT_W'(1);
  assign w_rd_inc   = r_rd_ptr + CNT_W'(1);
  assign w_wr_addr  = W_BASE + ADDR_W'(r_word_cnt);
  assign w_rd_addr  = W_BASE + ADDR_W'(r_rd_ptr);

`ifdef UART_SRAM_INC_EN
  assign w_tx_word = {r_hold[15:8], r_hold[7:0] + 8'd1};
`else
  assign w_tx_word = r_hold;
`endif

  always_comb begin
    w_next     = r_state;
    w_rdn      = 1'b1;
    w_wrn      = 1'b1;
    w_tx_drive = 1'b0;
    case (r_state)
      IDLE:      w_next = RX_POLL;
      RX_POLL:   if (data_ready) w_next = RX_STROBE;
      RX_STROBE: begin
        w_rdn  = 1'b0;
        w_next = RX_LATCH;
      end
      RX_LATCH:  w_next = WR_SETUP;
      WR_SETUP:  w_next = WR_PULSE;
      WR_PULSE:  w_next = WR_HOLD;
      WR_HOLD:   w_next = (w_word_inc < r_len) ? RX_POLL : RD_SETUP;
      RD_SETUP:  w_next = RD_LATCH;
      RD_LATCH:  w_next = TX_DRIVE;
      TX_DRIVE: begin
        w_tx_drive = 1'b1;
        w_next     = TX_PULSE;
      end
      TX_PULSE: begin
        w_tx_drive = 1'b1;
        w_wrn      = 1'b0;
        if (r_wcnt == WC_W'(WRN_CYC - 1)) w_next = TX_TBRE;
      end
      TX_TBRE: begin
        w_tx_drive = 1'b1;
        if (tbre) w_next = TX_TSRE;
      end
      TX_TSRE: begin
        w_tx_drive = 1'b1;
        if (tsre) w_next = (w_rd_inc < r_len) ? RD_SETUP : IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end

  // Bus bytes are captured on the edge that ends the low strobe, while the source still drives.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_len      <= CNT_W'(1);
      r_word_cnt <= '0;
      r_rd_ptr   <= '0;
      r_hold     <= '0;
      r_wcnt     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:      r_len <= (mode == MODE_BATCH) ? CNT_W'(DEPTH) : CNT_W'(1);
        RX_STROBE: r_hold <= {8'h00, data[7:0]};
        WR_HOLD: begin
          r_word_cnt <= w_word_inc;
          r_rd_ptr   <= '0;
        end
        RD_SETUP:  r_hold <= data;
        TX_DRIVE:  r_wcnt <= '0;
        TX_PULSE:  r_wcnt <= r_wcnt + WC_W'(1);
        TX_TSRE: begin
          if (tsre) begin
            r_rd_ptr <= w_rd_inc;
            if (!(w_rd_inc < r_len)) r_word_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  sram_word_port #(
    .ADDR_W(ADDR_W)
  ) u_word_port (
    .i_state  (r_state),
    .i_wr_addr(w_wr_addr),
    .i_rd_addr(w_rd_addr),
    .o_en_n   (Ram1_EN),
    .o_oe_n   (Ram1_OE),
    .o_we_n   (Ram1_WE),
    .o_addr   (Ram1_address),
    .o_drive  (w_ram_drive)
  );

  assign data     = w_ram_drive ? r_hold : (w_tx_drive ? w_tx_word : HIGH);
  assign rdn      = w_rdn;
  assign wrn      = w_wrn;
  assign word_cnt = r_word_cnt;
  assign busy     = (r_state != IDLE);

endmodule

// File: doc/uart_sram_batch_bridge.md
Name: uart_sram_batch_bridge

Overview:
- Parametrised successor to the single-word UART echo engine on the CPLD serial interface (data_ready/rdn/tbre/tsre/wrn) sharing the 16-bit data bus with RAM1.
- Collects DEPTH received bytes into RAM1 at consecutive addresses from BASE_ADDR, then reads them back and transmits them in order.
- A mode input selects per-word echo (DEPTH forced to 1 per round) or batch replay.
- Sits between the board serial chip and RAM1 as the standalone bring-up/loopback block.

Parameters:
- ADDR_W, 18, RAM1 address width.
- DEPTH, 8, words collected per batch; legal range 1..2^ADDR_W-BASE_ADDR.
- BASE_ADDR, 0, first RAM1 address used.
- WRN_CYC, 1, cycles wrn is held low per transmit strobe; minimum 1.
- CNT_W, $clog2(DEPTH+1), width of word counter.

Ports:
- CLK  in  1  system clock (11 MHz).
- RST  in  1  synchronous active-low reset, sampled on posedge CLK.
- mode  in  1  0 = echo each word, 1 = batch of DEPTH; sampled only in IDLE.
- data_ready  in  1  serial chip has a received byte.
- tbre  in  1  transmit buffer empty.
- tsre  in  1  transmit shift register empty.
- rdn  out  1  serial read strobe, active low.
- wrn  out  1  serial write strobe, active low.
- data  inout  16  shared bus; driven only when the block owns it, else 16'bz.
- Ram1_EN, Ram1_OE, Ram1_WE  out  1 each  RAM1 controls, active low.
- Ram1_address  out  ADDR_W  RAM1 address.
- word_cnt  out  CNT_W  words stored in current batch.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (RST low at posedge): rdn=wrn=1; Ram1_EN=Ram1_OE=Ram1_WE=1; bus released (z); Ram1_address=BASE_ADDR; word_cnt=0; busy=0; state=IDLE. Reset mid-transfer aborts immediately; no partial strobe survives the reset edge.
- States: IDLE, RX_POLL, RX_STROBE, RX_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_LATCH, TX_DRIVE, TX_PULSE, TX_TBRE, TX_TSRE.
- IDLE: latch mode into internal batch length (1 or DEPTH) -> RX_POLL.
- RX_POLL: bus released, rdn=1; if data_ready=1 -> RX_STROBE, else stay.
- RX_STROBE: rdn=0 -> RX_LATCH.
- RX_LATCH: capture {8'h00, data[7:0]} into holding register; rdn=1 -> WR_SETUP.
- WR_SETUP: drive held word, EN=0, OE=1, WE=1, address=BASE_ADDR+word_cnt.
- WR_PULSE: WE=0, one cycle.
- WR_HOLD: WE=1, bus still driven; word_cnt+1. If new count < batch length -> RX_POLL (EN=1, bus released); else reset read pointer to 0 -> RD_SETUP.
- RD_SETUP: bus released, EN=0, OE=0, address=BASE_ADDR+rd_ptr.
- RD_LATCH: capture data into holding register; EN=OE=1 -> TX_DRIVE.
- TX_DRIVE: drive holding register onto bus (one cycle setup).
- TX_PULSE: wrn=0 for WRN_CYC cycles, bus held; then wrn=1 -> TX_TBRE.
- TX_TBRE: wait tbre=1 -> TX_TSRE; TX_TSRE: wait tsre=1, release bus. rd_ptr+1; if rd_ptr < batch length -> RD_SETUP, else word_cnt=0 -> IDLE.
- Bus ownership: never drive data while rdn=0 or Ram1_OE=0; at most one of rdn, Ram1_OE, wrn is low in any cycle.
- Address arithmetic: ADDR_W-bit modular; BASE_ADDR+DEPTH-1 must not exceed 2^ADDR_W-1 (elaboration assertion).
- data_ready pulsing during RAM or TX phases is ignored; the byte is picked up at the next RX_POLL.
- mode changes outside IDLE have no effect on the current batch.

Optional Feature:
- Macro UART_SRAM_INC_EN.
- Defined: transmitted word = stored word + 1 (8-bit wrap, 8'hFF -> 8'h00), applied in TX_DRIVE; RAM contents unchanged.
- Undefined: transmitted word equals the stored word exactly.

Decomposition:
- Shared package: state enumeration, 16'bz HIGH constant, mode encodings (MODE_ECHO=0, MODE_BATCH=1).
- One natural sub-module: sram_word_port, the three-cycle RAM1 write/two-cycle read sequencer with tri-state control; the bridge FSM instances it.

Test Plan:
- mode=0, RX byte 8'h41 -> RAM1 addr BASE_ADDR written 16'h0041, WE low exactly 1 cycle, then wrn low WRN_CYC cycles with data=16'h0041; busy returns to 0.
- mode=1, DEPTH=4, RX 8'h01..8'h04 -> addrs 0..3 hold 0001..0004; no wrn pulse until fourth write completes; replay transmits 01,02,03,04 in order.
- tbre held 0 for 50 cycles after TX_PULSE -> FSM stays in TX_TBRE, bus still driven, no further RAM access; proceeds within 1 cycle of tbre=1 and tsre=1.
- RST low during WR_PULSE of word 2 -> next cycle all strobes high, bus z, word_cnt=0, state IDLE; new batch restarts at BASE_ADDR.
- Bus-contention monitor over random data_ready/tbre/tsre timing -> never data driven with rdn=0 or Ram1_OE=0; never two of rdn/Ram1_OE/wrn low at once.
- With UART_SRAM_INC_EN, RX 8'hFF -> RAM holds 16'h00FF, transmitted 16'h0000.
